// File: rtl/agu_split.sv
// Load/store address generation unit: effective address, window translation,
// fault detection, and splitting of word-crossing accesses into two aligned
// micro-ops behind a registered valid/ready output stage with branch flush.
module agu_split #(
  parameter int unsigned NUM_MAPS  = 4,
  parameter int unsigned WIN_BITS  = 11,
  parameter logic [7:0]  IO_PREFIX = 8'hff,
  parameter int unsigned SQN_W     = 6,
  parameter int unsigned TAG_W     = 12,
  parameter bit          SPLIT_EN  = 1'b1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_MAPS*(32-WIN_BITS)-1:0]   IN_mapping,
  input  logic [NUM_MAPS-1:0]                 IN_mapValid,
  input  logic                                IN_branchTaken,
  input  logic [SQN_W-1:0]                    IN_branchSqN,
  input  logic                                IN_valid,
  output logic                                OUT_inReady,
  input  logic [31:0]                         IN_srcA,
  input  logic [31:0]                         IN_srcB,
  input  logic [11:0]                         IN_imm,
  input  logic [2:0]                          IN_opcode,
  input  logic [SQN_W-1:0]                    IN_sqN,
  input  logic [TAG_W-1:0]                    IN_tag,
  output logic                                OUT_valid,
  input  logic                                IN_outReady,
  output logic [31:0]                         OUT_addr,
  output logic                                OUT_isLoad,
  output logic [1:0]                          OUT_size,
  output logic                                OUT_signExtend,
  output logic [1:0]                          OUT_shamt,
  output logic [3:0]                          OUT_wmask,
  output logic [31:0]                         OUT_data,
  output logic                                OUT_exception,
  output logic [1:0]                          OUT_split,
  output logic [SQN_W-1:0]                    OUT_sqN,
  output logic [TAG_W-1:0]                    OUT_tag
);

  localparam int unsigned MapTagW = 32 - WIN_BITS;
  localparam int unsigned IdxW    = (NUM_MAPS > 1) ? $clog2(NUM_MAPS) : 1;

  typedef enum logic [0:0] {StIdle, StSecond} state_e;

  // Returns {fault, physical}. IO region passes through; otherwise the lowest
  // matching enabled window supplies the index placed above the window offset.
  function automatic logic [32:0] translate(input logic [31:0]                  a,
                                            input logic [NUM_MAPS*MapTagW-1:0] maps,
                                            input logic [NUM_MAPS-1:0]         vld);
    logic [32:0] res;
    logic        hit;
    res                = '0;
    res[32]            = 1'b1;
    res[WIN_BITS-1:0]  = a[WIN_BITS-1:0];
    hit                = 1'b0;
    if (a[31:24] == IO_PREFIX) begin
      res = {1'b0, a};
      hit = 1'b1;
    end
    for (int i = 0; i < int'(NUM_MAPS); i++) begin
      if (!hit && vld[i] && (a[31:WIN_BITS] == maps[i*MapTagW +: MapTagW])) begin
        hit                   = 1'b1;
        res                   = '0;
        res[WIN_BITS-1:0]     = a[WIN_BITS-1:0];
        res[WIN_BITS +: IdxW] = IdxW'(i);
      end
    end
    return res;
  endfunction

  // Wrap-aware age compare against the flushing branch.
  function automatic logic younger(input logic [SQN_W-1:0] sqn,
                                   input logic             taken,
                                   input logic [SQN_W-1:0] bsqn);
    logic [SQN_W-1:0] diff;
    diff = sqn - bsqn;
    return taken && !diff[SQN_W-1] && (diff != '0);
  endfunction

  state_e             state_q, state_d;
  logic               out_valid_q, out_valid_d;
  logic [31:0]        out_addr_q, out_addr_d;
  logic               out_is_load_q, out_is_load_d;
  logic [1:0]         out_size_q, out_size_d;
  logic               out_sext_q, out_sext_d;
  logic [1:0]         out_shamt_q, out_shamt_d;
  logic [3:0]         out_wmask_q, out_wmask_d;
  logic [31:0]        out_data_q, out_data_d;
  logic               out_exc_q, out_exc_d;
  logic [1:0]         out_split_q, out_split_d;
  logic [SQN_W-1:0]   out_sqn_q, out_sqn_d;
  logic [TAG_W-1:0]   out_tag_q, out_tag_d;
  logic [31:0]        second_addr_q, second_addr_d;
  logic [3:0]         second_wmask_q, second_wmask_d;

  logic [31:0] ea;
  logic [31:0] ea_next_word;
  logic [3:0]  size_mask;
  logic [1:0]  size;
  logic        is_load;
  logic        sext;
  logic [7:0]  lanes;
  logic        crosses;
  logic [32:0] xl_first;
  logic [32:0] xl_second;
  logic        exc;
  logic        do_split;
  logic [31:0] data_rot;
  logic        in_ready;
  logic        accept;
  logic        in_young;
  logic        out_young;

  // Decode the incoming uop: address, lanes, translation and fault.
  always_comb begin
    ea           = IN_srcA + {{20{IN_imm[11]}}, IN_imm};
    ea_next_word = {ea[31:2] + 30'd1, 2'b00};

    size_mask = 4'b0001;
    size      = 2'd0;
    is_load   = 1'b1;
    sext      = 1'b0;
    unique case (IN_opcode)
      3'd0: begin size = 2'd0; size_mask = 4'b0001; is_load = 1'b1; sext = 1'b1; end
      3'd1: begin size = 2'd1; size_mask = 4'b0011; is_load = 1'b1; sext = 1'b1; end
      3'd2: begin size = 2'd2; size_mask = 4'b1111; is_load = 1'b1; sext = 1'b0; end
      3'd3: begin size = 2'd0; size_mask = 4'b0001; is_load = 1'b1; sext = 1'b0; end
      3'd4: begin size = 2'd1; size_mask = 4'b0011; is_load = 1'b1; sext = 1'b0; end
      3'd5: begin size = 2'd0; size_mask = 4'b0001; is_load = 1'b0; sext = 1'b0; end
      3'd6: begin size = 2'd1; size_mask = 4'b0011; is_load = 1'b0; sext = 1'b0; end
      3'd7: begin size = 2'd2; size_mask = 4'b1111; is_load = 1'b0; sext = 1'b0; end
      default: ;
    endcase

    lanes   = {4'b0000, size_mask} << ea[1:0];
    crosses = (lanes[7:4] != 4'b0000);

    xl_first  = translate(ea, IN_mapping, IN_mapValid);
    xl_second = translate(ea_next_word, IN_mapping, IN_mapValid);

    // Without splitting, a crossing access is itself the fault; with it, the
    // second half's window must also translate.
    exc      = (ea == 32'd0) || xl_first[32] || (crosses && (SPLIT_EN ? xl_second[32] : 1'b1));
    do_split = crosses && !exc;

    unique case (ea[1:0])
      2'd0: data_rot = IN_srcB;
      2'd1: data_rot = {IN_srcB[23:0], IN_srcB[31:24]};
      2'd2: data_rot = {IN_srcB[15:0], IN_srcB[31:16]};
      2'd3: data_rot = {IN_srcB[7:0],  IN_srcB[31:8]};
      default: data_rot = IN_srcB;
    endcase
  end

  // Handshake and flush qualifiers.
  always_comb begin
    in_ready  = (state_q == StIdle) && (!out_valid_q || IN_outReady);
    accept    = IN_valid && in_ready;
    in_young  = younger(IN_sqN, IN_branchTaken, IN_branchSqN);
    out_young = younger(out_sqn_q, IN_branchTaken, IN_branchSqN);
  end

  assign OUT_inReady = in_ready;

  // Next state of the FSM and the registered output stage.
  always_comb begin
    state_d        = state_q;
    out_valid_d    = out_valid_q;
    out_addr_d     = out_addr_q;
    out_is_load_d  = out_is_load_q;
    out_size_d     = out_size_q;
    out_sext_d     = out_sext_q;
    out_shamt_d    = out_shamt_q;
    out_wmask_d    = out_wmask_q;
    out_data_d     = out_data_q;
    out_exc_d      = out_exc_q;
    out_split_d    = out_split_q;
    out_sqn_d      = out_sqn_q;
    out_tag_d      = out_tag_q;
    second_addr_d  = second_addr_q;
    second_wmask_d = second_wmask_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (in_young) begin
            // Consumed but squashed by the concurrent flush.
            out_valid_d = 1'b0;
          end else begin
            out_valid_d   = 1'b1;
            out_addr_d    = do_split ? {xl_first[31:2], 2'b00} : xl_first[31:0];
            out_is_load_d = is_load;
            out_size_d    = size;
            out_sext_d    = sext;
            out_shamt_d   = ea[1:0];
            out_wmask_d   = lanes[3:0];
            out_data_d    = data_rot;
            out_exc_d     = exc;
            out_split_d   = do_split ? 2'b01 : 2'b00;
            out_sqn_d     = IN_sqN;
            out_tag_d     = IN_tag;
            if (do_split) begin
              second_addr_d  = xl_second[31:0];
              second_wmask_d = lanes[7:4];
              state_d        = StSecond;
            end
          end
        end else if (!out_valid_q || IN_outReady) begin
          out_valid_d = 1'b0;
        end else if (out_young) begin
          out_valid_d = 1'b0;
        end
      end
      StSecond: begin
        if (out_young) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end else if (IN_outReady) begin
          out_addr_d  = second_addr_q;
          out_wmask_d = second_wmask_q;
          out_split_d = 2'b11;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= StIdle;
      out_valid_q    <= 1'b0;
      out_addr_q     <= '0;
      out_is_load_q  <= 1'b0;
      out_size_q     <= '0;
      out_sext_q     <= 1'b0;
      out_shamt_q    <= '0;
      out_wmask_q    <= '0;
      out_data_q     <= '0;
      out_exc_q      <= 1'b0;
      out_split_q    <= '0;
      out_sqn_q      <= '0;
      out_tag_q      <= '0;
      second_addr_q  <= '0;
      second_wmask_q <= '0;
    end else begin
      state_q        <= state_d;
      out_valid_q    <= out_valid_d;
      out_addr_q     <= out_addr_d;
      out_is_load_q  <= out_is_load_d;
      out_size_q     <= out_size_d;
      out_sext_q     <= out_sext_d;
      out_shamt_q    <= out_shamt_d;
      out_wmask_q    <= out_wmask_d;
      out_data_q     <= out_data_d;
      out_exc_q      <= out_exc_d;
      out_split_q    <= out_split_d;
      out_sqn_q      <= out_sqn_d;
      out_tag_q      <= out_tag_d;
      second_addr_q  <= second_addr_d;
      second_wmask_q <= second_wmask_d;
    end
  end

  assign OUT_valid      = out_valid_q;
  assign OUT_addr       = out_addr_q;
  assign OUT_isLoad     = out_is_load_q;
  assign OUT_size       = out_size_q;
  assign OUT_signExtend = out_sext_q;
  assign OUT_shamt      = out_shamt_q;
  assign OUT_wmask      = out_wmask_q;
  assign OUT_data       = out_data_q;
  assign OUT_exception  = out_exc_q;
  assign OUT_split      = out_split_q;
  assign OUT_sqN        = out_sqn_q;
  assign OUT_tag        = out_tag_q;

endmodule

// File: tb/tb_agu_split.sv
// Bench for agu_split: directed scenarios followed by random traffic, all
// checked against a byte-level reference model and an expected-uop queue.
module tb_agu_split;

  logic        clk = 1'b0;
  logic        rst;
  logic [83:0] IN_mapping;
  logic [3:0]  IN_mapValid;
  logic        IN_branchTaken;
  logic [5:0]  IN_branchSqN;
  logic        IN_valid;
  logic        OUT_inReady;
  logic [31:0] IN_srcA;
  logic [31:0] IN_srcB;
  logic [11:0] IN_imm;
  logic [2:0]  IN_opcode;
  logic [5:0]  IN_sqN;
  logic [11:0] IN_tag;
  logic        OUT_valid;
  logic        IN_outReady;
  logic [31:0] OUT_addr;
  logic        OUT_isLoad;
  logic [1:0]  OUT_size;
  logic        OUT_signExtend;
  logic [1:0]  OUT_shamt;
  logic [3:0]  OUT_wmask;
  logic [31:0] OUT_data;
  logic        OUT_exception;
  logic [1:0]  OUT_split;
  logic [5:0]  OUT_sqN;
  logic [11:0] OUT_tag;

  always #5 clk = ~clk;

  agu_split #(
    .NUM_MAPS (4),
    .WIN_BITS (11),
    .IO_PREFIX(8'hff),
    .SQN_W    (6),
    .TAG_W    (12),
    .SPLIT_EN (1'b1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .IN_mapping    (IN_mapping),
    .IN_mapValid   (IN_mapValid),
    .IN_branchTaken(IN_branchTaken),
    .IN_branchSqN  (IN_branchSqN),
    .IN_valid      (IN_valid),
    .OUT_inReady   (OUT_inReady),
    .IN_srcA       (IN_srcA),
    .IN_srcB       (IN_srcB),
    .IN_imm        (IN_imm),
    .IN_opcode     (IN_opcode),
    .IN_sqN        (IN_sqN),
    .IN_tag        (IN_tag),
    .OUT_valid     (OUT_valid),
    .IN_outReady   (IN_outReady),
    .OUT_addr      (OUT_addr),
    .OUT_isLoad    (OUT_isLoad),
    .OUT_size      (OUT_size),
    .OUT_signExtend(OUT_signExtend),
    .OUT_shamt     (OUT_shamt),
    .OUT_wmask     (OUT_wmask),
    .OUT_data      (OUT_data),
    .OUT_exception (OUT_exception),
    .OUT_split     (OUT_split),
    .OUT_sqN       (OUT_sqN),
    .OUT_tag       (OUT_tag)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic        is_load;
    logic [1:0]  size;
    logic        sext;
    logic [1:0]  shamt;
    logic [3:0]  wmask;
    logic [31:0] data;
    logic        exc;
    logic [1:0]  split;
    logic [5:0]  sqn;
    logic [11:0] tag;
  } uop_t;

  uop_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  logic [20:0] map_tag [4];
  logic [3:0]  map_valid;
  uop_t        prev_obs;
  logic        prev_stall = 1'b0;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h, want %h", name, obs, exp);
    end
  endtask

  task automatic apply_maps();
    IN_mapping  = {map_tag[3], map_tag[2], map_tag[1], map_tag[0]};
    IN_mapValid = map_valid;
  endtask

  task automatic set_in(input logic [31:0] a, input logic [11:0] imm, input logic [2:0] op,
                        input logic [31:0] b, input logic [5:0] sqn);
    IN_valid  = 1'b1;
    IN_srcA   = a;
    IN_imm    = imm;
    IN_opcode = op;
    IN_srcB   = b;
    IN_sqN    = sqn;
    IN_tag    = {6'h2a, sqn};
  endtask

  // {fault, physical}: windows are 2 KiB, index i lands at i*2048.
  function automatic logic [32:0] ref_xlate(input logic [31:0] a);
    if (a[31:24] == 8'hff) return {1'b0, a};
    for (int i = 0; i < 4; i++) begin
      if (map_valid[i] && ((a >> 11) == {11'b0, map_tag[i]}))
        return {1'b0, 32'(i * 2048) + (a % 32'd2048)};
    end
    return {1'b1, a % 32'd2048};
  endfunction

  function automatic logic is_younger(input logic [5:0] sqn);
    logic [5:0] d;
    d = sqn - IN_branchSqN;
    return IN_branchTaken && ($signed(d) > 0);
  endfunction

  // Enqueue the uop(s) the current input should produce.
  task automatic model_push();
    logic [31:0] ea;
    int          nb;
    int          off;
    logic [3:0]  lo;
    logic [3:0]  hi;
    logic [63:0] rr;
    logic [32:0] t1;
    logic [32:0] t2;
    uop_t        u;
    ea = IN_srcA + {{20{IN_imm[11]}}, IN_imm};
    case (IN_opcode)
      3'd0, 3'd3, 3'd5: nb = 1;
      3'd1, 3'd4, 3'd6: nb = 2;
      default:          nb = 4;
    endcase
    off = int'(ea[1:0]);
    lo  = '0;
    hi  = '0;
    for (int b = 0; b < nb; b++) begin
      if (off + b < 4) lo[off + b] = 1'b1;
      else             hi[off + b - 4] = 1'b1;
    end
    t1 = ref_xlate(ea);
    t2 = ref_xlate({ea[31:2], 2'b00} + 32'd4);
    u.is_load = (IN_opcode < 3'd5);
    u.size    = (nb == 1) ? 2'd0 : (nb == 2) ? 2'd1 : 2'd2;
    u.sext    = (IN_opcode <= 3'd1);
    u.shamt   = ea[1:0];
    rr        = {IN_srcB, IN_srcB} << (8 * off);
    u.data    = u.is_load ? 32'h0 : rr[63:32];
    u.exc     = (ea == 32'd0) || t1[32] || ((hi != 4'd0) && t2[32]);
    u.sqn     = IN_sqN;
    u.tag     = IN_tag;
    if ((hi != 4'd0) && !u.exc) begin
      u.addr = {t1[31:2], 2'b00}; u.wmask = lo; u.split = 2'b01; exp_q.push_back(u);
      u.addr = t2[31:0];          u.wmask = hi; u.split = 2'b11; exp_q.push_back(u);
    end else begin
      u.addr = t1[31:0]; u.wmask = lo; u.split = 2'b00; exp_q.push_back(u);
    end
  endtask

  // One clock: sample at the falling edge, score, then return just after the
  // rising edge so the caller can drive the next inputs.
  task automatic cycle();
    uop_t obs;
    uop_t cmp;
    uop_t e;
    @(negedge clk);
    obs = '{addr: OUT_addr, is_load: OUT_isLoad, size: OUT_size, sext: OUT_signExtend,
            shamt: OUT_shamt, wmask: OUT_wmask, data: OUT_data, exc: OUT_exception,
            split: OUT_split, sqn: OUT_sqN, tag: OUT_tag};
    chk("out_valid", 32'(OUT_valid), 32'(exp_q.size() != 0));
    chk("in_ready", 32'(OUT_inReady), 32'((exp_q.size() < 2) && (!OUT_valid || IN_outReady)));
    if (prev_stall) begin
      checks++;
      assert (obs === prev_obs && OUT_valid === 1'b1) else begin
        errors++;
        $error("FAIL hold: got %h v=%b, want %h v=1", obs, OUT_valid, prev_obs);
      end
    end
    prev_stall = OUT_valid && !IN_outReady && !IN_branchTaken;
    prev_obs   = obs;
    if (OUT_valid && IN_outReady && exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      cmp = obs;
      if (e.is_load) cmp.data = 32'h0;
      checks++;
      assert (cmp === e) else begin
        errors++;
        $error("FAIL uop: got %h, want %h", cmp, e);
      end
    end
    if (IN_branchTaken) begin
      for (int i = exp_q.size() - 1; i >= 0; i--)
        if (is_younger(exp_q[i].sqn)) exp_q.delete(i);
    end
    if (IN_valid && OUT_inReady && !is_younger(IN_sqN)) model_push();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] bases [6];

  initial begin
    rst            = 1'b0;
    IN_valid       = 1'b0;
    IN_outReady    = 1'b1;
    IN_branchTaken = 1'b0;
    IN_branchSqN   = '0;
    IN_srcA        = '0;
    IN_srcB        = '0;
    IN_imm         = '0;
    IN_opcode      = '0;
    IN_sqN         = '0;
    IN_tag         = '0;
    map_tag[0] = 21'h00100; map_tag[1] = 21'h00101;
    map_tag[2] = 21'h1fffff; map_tag[3] = 21'h00a00;
    map_valid  = 4'b0001;
    apply_maps();

    // Reset state.
    #3;
    chk("rst_valid", 32'(OUT_valid), 32'd0);
    chk("rst_addr", OUT_addr, 32'd0);
    chk("rst_split", 32'(OUT_split), 32'd0);
    chk("rst_inready", 32'(OUT_inReady), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Aligned LW through window 0, one-cycle latency.
    set_in(32'h00080010, 12'hffc, 3'd2, 32'h0, 6'd1);
    cycle();
    IN_valid = 1'b0;
    chk("t1_valid", 32'(OUT_valid), 32'd1);
    chk("t1_addr", OUT_addr, 32'h0000000c);
    chk("t1_wmask", 32'(OUT_wmask), 32'hf);
    chk("t1_exc", 32'(OUT_exception), 32'd0);
    cycle();

    // SH crossing a word: two halves.
    set_in(32'h00080003, 12'h000, 3'd6, 32'h0000beef, 6'd2);
    cycle();
    IN_valid = 1'b0;
    chk("t2_addr0", OUT_addr, 32'h0);
    chk("t2_mask0", 32'(OUT_wmask), 32'h8);
    chk("t2_data0", OUT_data, 32'hef0000be);
    chk("t2_split0", 32'(OUT_split), 32'h1);
    cycle();
    chk("t2_addr1", OUT_addr, 32'h4);
    chk("t2_mask1", 32'(OUT_wmask), 32'h1);
    chk("t2_data1", OUT_data, 32'hef0000be);
    chk("t2_split1", 32'(OUT_split), 32'h3);
    cycle();

    // LW crossing into window 1, then with window 1 disabled.
    map_valid = 4'b0011;
    apply_maps();
    set_in(32'h00080800, 12'hffe, 3'd2, 32'h0, 6'd3);
    cycle();
    IN_valid = 1'b0;
    chk("t3_addr0", OUT_addr, 32'h000007fc);
    chk("t3_shamt0", 32'(OUT_shamt), 32'd2);
    cycle();
    chk("t3_addr1", OUT_addr, 32'h00000800);
    chk("t3_shamt1", 32'(OUT_shamt), 32'd2);
    cycle();
    map_valid = 4'b0001;
    apply_maps();
    set_in(32'h00080800, 12'hffe, 3'd2, 32'h0, 6'd4);
    cycle();
    IN_valid = 1'b0;
    chk("t3_exc", 32'(OUT_exception), 32'd1);
    chk("t3_nosplit", 32'(OUT_split), 32'd0);
    chk("t3_mask", 32'(OUT_wmask), 32'hc);
    cycle();

    // Back-pressure during a split; a queued input waits for the second half.
    IN_outReady = 1'b0;
    set_in(32'h00080003, 12'h000, 3'd6, 32'h12345678, 6'd5);
    cycle();
    set_in(32'h00080010, 12'h000, 3'd2, 32'h0, 6'd6);
    for (int i = 0; i < 3; i++) begin
      chk("t4_ready_hold", 32'(OUT_inReady), 32'd0);
      chk("t4_split_hold", 32'(OUT_split), 32'd1);
      cycle();
    end
    IN_outReady = 1'b1;
    #1;
    chk("t4_ready_second", 32'(OUT_inReady), 32'd0);
    cycle();
    chk("t4_split1", 32'(OUT_split), 32'd3);
    chk("t4_ready_idle", 32'(OUT_inReady), 32'd1);
    cycle();
    IN_valid = 1'b0;
    chk("t4_next_addr", OUT_addr, 32'h00000010);
    chk("t4_next_sqn", 32'(OUT_sqN), 32'd6);
    cycle();

    // Flush of a pending split: younger is dropped, older proceeds.
    IN_outReady = 1'b0;
    set_in(32'h00080003, 12'h000, 3'd6, 32'hcafef00d, 6'd10);
    cycle();
    IN_valid       = 1'b0;
    IN_branchTaken = 1'b1;
    IN_branchSqN   = 6'd8;
    cycle();
    IN_branchTaken = 1'b0;
    chk("t5_drop", 32'(OUT_valid), 32'd0);
    IN_outReady = 1'b1;
    cycle();
    chk("t5_no_second", 32'(OUT_valid), 32'd0);
    IN_outReady = 1'b0;
    set_in(32'h00080003, 12'h000, 3'd6, 32'hcafef00d, 6'd10);
    cycle();
    IN_valid       = 1'b0;
    IN_branchTaken = 1'b1;
    IN_branchSqN   = 6'd12;
    cycle();
    IN_branchTaken = 1'b0;
    chk("t5_keep", 32'(OUT_valid), 32'd1);
    chk("t5_keep_split", 32'(OUT_split), 32'd1);
    IN_outReady = 1'b1;
    cycle();
    chk("t5_second", 32'(OUT_split), 32'd3);
    cycle();

    // Asynchronous reset mid-split, then null and IO-region accesses.
    IN_outReady = 1'b0;
    set_in(32'h00080003, 12'h000, 3'd6, 32'h0, 6'd11);
    cycle();
    IN_valid = 1'b0;
    #2;
    rst = 1'b0;
    exp_q.delete();
    prev_stall = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(OUT_valid), 32'd0);
    chk("t6_rst_ready", 32'(OUT_inReady), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    IN_outReady = 1'b1;
    set_in(32'h0, 12'h000, 3'd0, 32'h0, 6'd12);
    cycle();
    IN_valid = 1'b0;
    chk("t6_null_exc", 32'(OUT_exception), 32'd1);
    cycle();
    set_in(32'hff000000, 12'h004, 3'd2, 32'h0, 6'd13);
    cycle();
    IN_valid = 1'b0;
    chk("t6_io_addr", OUT_addr, 32'hff000004);
    chk("t6_io_exc", 32'(OUT_exception), 32'd0);
    cycle();

    // Random traffic with back-pressure and flushes.
    bases = '{32'h00080000, 32'h00080800, 32'h00500000, 32'hff000000, 32'h00300000,
              32'h000807f0};
    map_valid = 4'b1011;
    apply_maps();
    for (int n = 0; n < 800; n++) begin
      if (n == 400) begin
        map_valid = 4'b0111;
        apply_maps();
      end
      IN_valid  = ($urandom_range(0, 9) < 7);
      IN_opcode = 3'($urandom_range(0, 7));
      IN_imm    = 12'($urandom());
      IN_srcA   = bases[$urandom_range(0, 5)] + 32'($urandom_range(0, 2047));
      if ($urandom_range(0, 19) == 0) IN_srcA = -{{20{IN_imm[11]}}, IN_imm};
      IN_srcB        = $urandom();
      IN_sqN         = 6'($urandom());
      IN_tag         = 12'($urandom());
      IN_outReady    = ($urandom_range(0, 9) < 7);
      IN_branchTaken = ($urandom_range(0, 9) == 0);
      IN_branchSqN   = 6'($urandom());
      cycle();
    end

    // Drain.
    IN_valid       = 1'b0;
    IN_branchTaken = 1'b0;
    IN_outReady    = 1'b1;
    for (int i = 0; i < 10; i++) cycle();
    chk("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
